// File: rtl/regfile_mp_if.sv
// Register-file port bundle: two write ports, two read ports with scoreboard
// status, scoreboard set, and clear-sweep request/status.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] wa0;
   logic [ADDR_W-1:0] wa1;
   logic [DATA_W-1:0] wd0;
   logic [DATA_W-1:0] wd1;
   logic [ADDR_W-1:0] ra0;
   logic [ADDR_W-1:0] ra1;
   logic [DATA_W-1:0] rd0;
   logic [DATA_W-1:0] rd1;
   logic              busy0;
   logic              busy1;
   logic              sb_set;
   logic [ADDR_W-1:0] sb_addr;
   logic              clr_req;
   logic              clr_busy;
   logic              ready;

   modport master (
      output we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, sb_set, sb_addr, clr_req,
      input  rd0, rd1, busy0, busy1, clr_busy, ready
   );

   modport slave (
      input  we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, sb_set, sb_addr, clr_req,
      output rd0, rd1, busy0, busy1, clr_busy, ready
   );
endinterface

// File: rtl/regfile_mp.sv
// 2W/2R register file with per-register pending scoreboard and a one-register-per-cycle clear sweep.
// Reads are combinational with write bypass; writes/sb_set are dropped while the sweep holds ready low.
module regfile_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);
   localparam int NREGS = 2**ADDR_W;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [NREGS-1:0]  sb_q, sb_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   logic ready;
   logic wr0_ok, wr1_ok, sb_ok;

   assign ready  = (state_q == ST_IDLE);
   assign wr0_ok = ready && bus.we0 && !(ZERO_R0 && (bus.wa0 == '0));
   assign wr1_ok = ready && bus.we1 && !(ZERO_R0 && (bus.wa1 == '0));
   assign sb_ok  = ready && bus.sb_set && !(ZERO_R0 && (bus.sb_addr == '0));

   always_comb begin
      regs_d  = regs_q;
      sb_d    = sb_q;
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == ST_IDLE) begin
         // Port 1 is applied after port 0 so it wins an address collision;
         // sb_set is applied last so it survives a same-address write-clear.
         if (wr0_ok) begin
            regs_d[bus.wa0] = bus.wd0;
            sb_d[bus.wa0]   = 1'b0;
         end
         if (wr1_ok) begin
            regs_d[bus.wa1] = bus.wd1;
            sb_d[bus.wa1]   = 1'b0;
         end
         if (sb_ok) begin
            sb_d[bus.sb_addr] = 1'b1;
         end
         if (bus.clr_req) begin
            state_d = ST_SWEEP;
            idx_d   = '0;
         end
      end else begin
         regs_d[idx_q] = '0;
         sb_d[idx_q]   = 1'b0;
         if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sb_q    <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sb_q    <= sb_d;
         regs_q  <= regs_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] ra);
      if (ZERO_R0 && (ra == '0)) begin
         return '0;
      end else if (ready && bus.we1 && (bus.wa1 == ra)) begin
         return bus.wd1;
      end else if (ready && bus.we0 && (bus.wa0 == ra)) begin
         return bus.wd0;
      end
      return regs_q[ra];
   endfunction

   assign bus.rd0      = read_mux(bus.ra0);
   assign bus.rd1      = read_mux(bus.ra1);
   assign bus.busy0    = sb_q[bus.ra0];
   assign bus.busy1    = sb_q[bus.ra1];
   assign bus.clr_busy = !ready;
   assign bus.ready    = ready;
endmodule
